apb_uart_regs_fifo: RTL and testbench
=====================================

APB_UART_REGS_FIFO -- requirements
Module: apb_uart_regs_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the UART data width and the FIFO entry width (5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the entries per FIFO (power of 2, range 2..64).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-004 SHALL have the following ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  12  byte address
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte lane strobes
- prdata_o  out  32  read data
- pready_o  out  1  transfer ready
- pslverr_o  out  1  transfer error
- tx_data_o  out  DATA_W  TX FIFO head
- tx_valid_o  out  1  TX FIFO non-empty
- tx_ready_i  in  1  UART TX accepts the head
- rx_data_i  in  DATA_W  received word
- rx_valid_i  in  1  one-cycle receive pulse
- parity_error_i  in  1  one-cycle parity error pulse
- data_bit_num_o  out  2  CFG[1:0]
- stop_bit_num_o, parity_en_o, parity_type_o  out  1 each  CFG[2], CFG[3], CFG[4]
- irq_o  out  1  interrupt, level

Function
REQ-005 SHALL define the access cycle as acc = psel_i & penable_i; pready_o SHALL be constant 1 (zero wait states).
REQ-006 SHALL implement this register map:
- 0x00 TXDATA: write pushes; reads return 0.
- 0x04 RXDATA: read pops the head.
- 0x08 CFG: RW, bits [4:0].
- 0x0C IER: RW, bits [3:0].
- 0x10 STATUS: RO. [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_count, [23:16] rx_count.
- 0x14 ISR: sticky, write-1-to-clear, bits [3:0].
REQ-007 SHALL, on CFG/IER writes, update each byte lane only where pstrb_i bit is 1; unimplemented bits read 0.
REQ-008 SHALL, on a TXDATA write with pstrb_i[0]=1 and TX FIFO not full, push pwdata_i[DATA_W-1:0] at the clk edge ending the access.
REQ-009 SHALL assert pslverr_o combinationally during acc for:
- an unmapped address;
- a write to RXDATA or STATUS;
- a TXDATA write while the TX FIFO is full (data dropped, count unchanged);
- an RXDATA read while the RX FIFO is empty (prdata_o = 0, no pop).
REQ-010 SHALL drive prdata_o combinationally during a read acc, with DATA_W data zero-extended; it SHALL be 0 outside a read acc.
REQ-011 SHALL drive tx_valid_o = TX FIFO non-empty and tx_data_o = head; a pop occurs on a cycle where tx_valid_o & tx_ready_i.
REQ-012 SHALL push rx_data_i on rx_valid_i when the RX FIFO is not full; when full, the word SHALL be dropped and ISR[3] set.
REQ-013 SHALL evaluate full/empty from the start-of-cycle count; a push and a pop in one cycle on the same non-empty, non-full FIFO SHALL leave the count unchanged.
REQ-014 SHALL use full/empty rules that are not relaxed by a same-cycle pop or push (a full FIFO rejects a push even if popped that cycle).
REQ-015 SHALL use pointers of log2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH; counts SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-016 SHALL set ISR bits on these events:
- [0] when the TX FIFO transitions to empty;
- [1] when an RX push succeeds;
- [2] on parity_error_i;
- [3] on RX overrun.
REQ-017 SHALL give set priority over a same-cycle W1C of the same bit.
REQ-018 SHALL drive irq_o = |(ISR & IER), registered (one cycle after the ISR update).

Reset
REQ-019 SHALL, on reset_n low, asynchronously clear:
- both FIFOs (pointers and counts = 0);
- CFG, IER, ISR and irq_o = 0;
- tx_valid_o = 0 and tx_data_o = 0.
REQ-020 SHALL, on reset mid-transfer, discard all FIFO contents; the first access after release SHALL observe STATUS = 0x00000005.

Verification
REQ-021 SHALL cover reset followed by a STATUS read -> 0x00000005, irq_o = 0, pslverr_o = 0.
REQ-022 SHALL cover 9 TXDATA writes 0x41..0x49 with tx_ready_i=0, DEPTH 8:
- writes 1..8 OK; write 9 gives pslverr_o = 1;
- STATUS[15:8] = 8, tx_full = 1;
- then tx_ready_i=1 for 8 cycles yields 0x41..0x48 in order, and ISR[0] = 1.
REQ-023 SHALL cover 9 rx_valid_i pulses 0x10..0x18:
- ISR[3] = 1;
- 8 RXDATA reads return 0x10..0x17;
- a 9th read gives pslverr_o = 1 with prdata_o = 0.
REQ-024 SHALL cover IER = 0x2 followed by one rx_valid_i:
- irq_o = 1 one cycle after ISR[1] sets;
- a W1C of 0x2 to ISR gives irq_o = 0 next cycle;
- a W1C coinciding with a new rx_valid_i leaves ISR[1] = 1.
REQ-025 SHALL cover a CFG write of 0x0000001F with pstrb_i = 4'b0010 -> CFG unchanged (0); the same write with pstrb_i = 4'b0001 -> data_bit_num_o = 3, stop/parity_en/parity_type = 1.
REQ-026 SHALL cover a simultaneous TX push and pop at count 3 -> count stays 3 and order is preserved; pointers wrap after 20 push/pop pairs with data intact.

Source files
------------

// File: rtl/apb_uart_regs_fifo.sv
// apb_uart_regs_fifo: APB register front-end for a UART with TX/RX FIFOs, sticky ISR and level irq.
module apb_uart_regs_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
    // Full/empty come from the start-of-cycle count, so a same-cycle pop never frees room for a push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    always_comb begin
        mem_d  = mem_q;
        wptr_d = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = do_pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) mem_d[wptr_q] = wdata_i;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module apb_uart_regs_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [11:0]       paddr_i,
    input  logic [31:0]       pwdata_i,
    input  logic [3:0]        pstrb_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic              parity_error_i,
    output logic [1:0]        data_bit_num_o,
    output logic              stop_bit_num_o,
    output logic              parity_en_o,
    output logic              parity_type_o,
    output logic              irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [4:0]        cfg_q, cfg_d;
    logic [3:0]        ier_q, ier_d, isr_q, isr_d, isr_set;
    logic              irq_q, irq_d;
    logic              acc, wr, rd, a_tx, a_rx, a_cfg, a_ier, a_st, a_isr, mapped;
    logic              tx_push, tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic [DATA_W-1:0] rx_head;
    logic [31:0]       status;
    logic              unused_ok;
    assign unused_ok = &{1'b0, pwdata_i[31:DATA_W], pstrb_i[3:1]};
    assign acc    = psel_i & penable_i;
    assign wr     = acc & pwrite_i;
    assign rd     = acc & ~pwrite_i;
    assign a_tx   = paddr_i == 12'h000;
    assign a_rx   = paddr_i == 12'h004;
    assign a_cfg  = paddr_i == 12'h008;
    assign a_ier  = paddr_i == 12'h00C;
    assign a_st   = paddr_i == 12'h010;
    assign a_isr  = paddr_i == 12'h014;
    assign mapped = a_tx | a_rx | a_cfg | a_ier | a_st | a_isr;
    assign pready_o  = 1'b1;
    assign pslverr_o = acc & (~mapped | (pwrite_i & (a_rx | a_st | (a_tx & tx_full))) |
                              (~pwrite_i & a_rx & rx_empty));
    assign tx_push    = wr & a_tx & pstrb_i[0];
    assign tx_valid_o = ~tx_empty;
    apb_uart_regs_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk, .reset_n, .push_i(tx_push), .pop_i(tx_ready_i), .wdata_i(pwdata_i[DATA_W-1:0]),
        .rdata_o(tx_data_o), .count_o(tx_cnt), .full_o(tx_full), .empty_o(tx_empty)
    );
    apb_uart_regs_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk, .reset_n, .push_i(rx_valid_i), .pop_i(rd & a_rx), .wdata_i(rx_data_i),
        .rdata_o(rx_head), .count_o(rx_cnt), .full_o(rx_full), .empty_o(rx_empty)
    );
    assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 4'h0, rx_full, rx_empty, tx_full, tx_empty};
    // TX goes empty only when the last word leaves with no accepted push in the same cycle.
    assign isr_set = {rx_valid_i & rx_full, parity_error_i, rx_valid_i & ~rx_full,
                      tx_valid_o & tx_ready_i & (tx_cnt == CW'(1)) & ~(tx_push & ~tx_full)};
    always_comb begin
        cfg_d = (wr & a_cfg & pstrb_i[0]) ? pwdata_i[4:0] : cfg_q;
        ier_d = (wr & a_ier & pstrb_i[0]) ? pwdata_i[3:0] : ier_q;
        isr_d = (isr_q & ~((wr & a_isr) ? pwdata_i[3:0] : 4'h0)) | isr_set;
        irq_d = |(isr_q & ier_q);
        prdata_o = !rd  ? 32'h0 :
                   a_rx  ? 32'(rx_head) :
                   a_cfg ? 32'(cfg_q) :
                   a_ier ? 32'(ier_q) :
                   a_st  ? status :
                   a_isr ? 32'(isr_q) : 32'h0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q <= '0;
            ier_q <= '0;
            isr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= irq_d;
        end
    end
    assign irq_o          = irq_q;
    assign data_bit_num_o = cfg_q[1:0];
    assign stop_bit_num_o = cfg_q[2];
    assign parity_en_o    = cfg_q[3];
    assign parity_type_o  = cfg_q[4];
endmodule

// File: tb/tb_apb_uart_regs_fifo.sv
// tb_apb_uart_regs_fifo: directed self-checking bench for apb_uart_regs_fifo (DATA_W=8, FIFO_DEPTH=8).
module tb_apb_uart_regs_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [11:0] paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic [3:0]  pstrb_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0, parity_error_i = 1'b0;
    logic [1:0]  data_bit_num_o;
    logic        stop_bit_num_o, parity_en_o, parity_type_o, irq_o;
    int          errors = 0;
    int          checks = 0;

    apb_uart_regs_fifo dut (
        .clk(clk), .reset_n(reset_n), .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .parity_error_i(parity_error_i), .data_bit_num_o(data_bit_num_o),
        .stop_bit_num_o(stop_bit_num_o), .parity_en_o(parity_en_o),
        .parity_type_o(parity_type_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic e);
        @(negedge clk);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d; pstrb_i = s;
        @(negedge clk);
        penable_i = 1'b1;
        #1 e = pslverr_o;
        @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
        @(negedge clk);
        penable_i = 1'b1;
        #1 begin d = prdata_o; e = pslverr_o; end
        @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    // TXDATA write whose access cycle also pops the TX head; returns the head seen during that cycle.
    task automatic apb_write_pop(input logic [7:0] d, output logic [7:0] head, output logic e);
        @(negedge clk);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 12'h000; pwdata_i = 32'(d);
        pstrb_i = 4'hF;
        @(negedge clk);
        penable_i = 1'b1; tx_ready_i = 1'b1;
        #1 begin head = tx_data_o; e = pslverr_o; end
        @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; tx_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        e;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (irq_o !== 1'b0 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b tx_valid=%b tx_data=%h, required 0 0 00", irq_o, tx_valid_o, tx_data_o);
        end
        apb_read(12'h010, d, e);
        checks++;
        if (d !== 32'h5 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got %h err=%b, required 00000005 err=0", d, e);
        end
    endtask

    task automatic test_tx_fill;
        logic [31:0] d;
        logic        e;
        for (int i = 0; i < 9; i++) begin
            apb_write(12'h000, 32'h41 + 32'(i), 4'hF, e);
            checks++;
            if (e !== (i == 8)) begin
                errors++;
                $display("FAIL tx_write_%0d: pslverr=%b, required %b", i, e, i == 8);
            end
        end
        apb_read(12'h010, d, e);
        checks++;
        if (d !== 32'h0000_0806) begin
            errors++;
            $display("FAIL tx_full_status: got %h, required 00000806", d);
        end
        @(negedge clk);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41 + 8'(i)) begin
                errors++;
                $display("FAIL tx_drain_%0d: valid=%b data=%h, required 1 %h", i, tx_valid_o, tx_data_o, 8'h41 + 8'(i));
            end
            @(negedge clk);
        end
        tx_ready_i = 1'b0;
        checks++;
        if (tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL tx_drained_valid: got %b, required 0", tx_valid_o);
        end
        apb_read(12'h014, d, e);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL tx_empty_isr: got %h, required 00000001", d);
        end
        apb_write(12'h014, 32'hF, 4'hF, e);
        apb_read(12'h014, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL isr_w1c: got %h, required 00000000", d);
        end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] d;
        logic        e;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rx_valid_i = 1'b1; rx_data_i = 8'h10 + 8'(i);
        end
        @(negedge clk);
        rx_valid_i = 1'b0; parity_error_i = 1'b1;
        @(negedge clk);
        parity_error_i = 1'b0;
        apb_read(12'h014, d, e);
        checks++;
        if (d !== 32'hE) begin
            errors++;
            $display("FAIL rx_overrun_isr: got %h, required 0000000e", d);
        end
        apb_read(12'h010, d, e);
        checks++;
        if (d !== 32'h0008_0009) begin
            errors++;
            $display("FAIL rx_full_status: got %h, required 00080009", d);
        end
        for (int i = 0; i < 9; i++) begin
            apb_read(12'h004, d, e);
            checks++;
            if (d !== (i < 8 ? 32'h10 + 32'(i) : 32'h0) || e !== (i == 8)) begin
                errors++;
                $display("FAIL rx_read_%0d: got %h err=%b, required %h err=%b", i, d, e,
                         i < 8 ? 32'h10 + 32'(i) : 32'h0, i == 8);
            end
        end
        apb_write(12'h014, 32'hF, 4'hF, e);
    endtask

    task automatic test_irq;
        logic [31:0] d;
        logic        e;
        apb_write(12'h00C, 32'h2, 4'hF, e);
        @(negedge clk);
        rx_valid_i = 1'b1; rx_data_i = 8'h33;
        @(negedge clk);
        rx_valid_i = 1'b0;
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency_early: got %b, required 0", irq_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b, required 1", irq_o);
        end
        apb_write(12'h014, 32'h2, 4'hF, e);
        #1;
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_clear_early: got %b, required 1", irq_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b, required 0", irq_o);
        end
        apb_read(12'h004, d, e);
        // W1C of ISR[1] in the same cycle as a fresh receive: the set must win.
        @(negedge clk);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 12'h014; pwdata_i = 32'h2; pstrb_i = 4'hF;
        @(negedge clk);
        penable_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h77;
        @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; rx_valid_i = 1'b0;
        apb_read(12'h014, d, e);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL isr_set_priority: got %h, required 00000002", d);
        end
        apb_read(12'h004, d, e);
        checks++;
        if (d !== 32'h77 || e !== 1'b0) begin
            errors++;
            $display("FAIL rx_priority_data: got %h err=%b, required 00000077 err=0", d, e);
        end
        apb_write(12'h014, 32'hF, 4'hF, e);
        apb_write(12'h00C, 32'h0, 4'hF, e);
    endtask

    task automatic test_cfg;
        logic [31:0] d;
        logic        e;
        apb_write(12'h008, 32'h1F, 4'b0010, e);
        apb_read(12'h008, d, e);
        checks++;
        if (d !== 32'h0 || data_bit_num_o !== 2'd0) begin
            errors++;
            $display("FAIL cfg_strb_masked: got %h dbn=%0d, required 00000000 dbn=0", d, data_bit_num_o);
        end
        apb_write(12'h008, 32'h1F, 4'b0001, e);
        apb_read(12'h008, d, e);
        checks++;
        if (d !== 32'h1F || data_bit_num_o !== 2'd3 || stop_bit_num_o !== 1'b1 ||
            parity_en_o !== 1'b1 || parity_type_o !== 1'b1) begin
            errors++;
            $display("FAIL cfg_write: got %h dbn=%0d stop=%b pen=%b ptype=%b, required 0000001f 3 1 1 1",
                     d, data_bit_num_o, stop_bit_num_o, parity_en_o, parity_type_o);
        end
        apb_read(12'h018, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: err=%b data=%h, required err=1 data=0", e, d);
        end
        apb_write(12'h010, 32'h0, 4'hF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL status_write_err: err=%b, required 1", e);
        end
        apb_read(12'h000, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'h0 || pready_o !== 1'b1) begin
            errors++;
            $display("FAIL txdata_read: err=%b data=%h pready=%b, required 0 0 1", e, d, pready_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [7:0]  h;
        logic        e;
        for (int i = 0; i < 3; i++) apb_write(12'h000, 32'hA0 + 32'(i), 4'hF, e);
        apb_write_pop(8'hA3, h, e);
        checks++;
        if (h !== 8'hA0 || e !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_head: got %h err=%b, required a0 err=0", h, e);
        end
        apb_read(12'h010, d, e);
        checks++;
        if (d !== 32'h0000_0304) begin
            errors++;
            $display("FAIL pushpop_count: got %h, required 00000304", d);
        end
        @(negedge clk);
        tx_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            checks++;
            if (tx_data_o !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL pushpop_order_%0d: got %h, required %h", i, tx_data_o, 8'hA0 + 8'(i));
            end
            @(negedge clk);
        end
        tx_ready_i = 1'b0;
        apb_write(12'h000, 32'h60, 4'hF, e);
        for (int i = 1; i <= 20; i++) begin
            apb_write_pop(8'h60 + 8'(i), h, e);
            checks++;
            if (h !== 8'h60 + 8'(i - 1) || e !== 1'b0) begin
                errors++;
                $display("FAIL wrap_%0d: got %h err=%b, required %h err=0", i, h, e, 8'h60 + 8'(i - 1));
            end
        end
        #1;
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h74) begin
            errors++;
            $display("FAIL wrap_last: valid=%b data=%h, required 1 74", tx_valid_o, tx_data_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        e;
        apb_write(12'h000, 32'h99, 4'hF, e);
        @(negedge clk);
        rx_valid_i = 1'b1; rx_data_i = 8'h5A;
        @(negedge clk);
        rx_valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || data_bit_num_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h dbn=%0d, required 0 00 0", tx_valid_o, tx_data_o, data_bit_num_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        apb_read(12'h010, d, e);
        checks++;
        if (d !== 32'h5 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_status: got %h err=%b, required 00000005 err=0", d, e);
        end
    endtask

    initial begin
        test_reset;
        test_tx_fill;
        test_rx_overrun;
        test_irq;
        test_cfg;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
